// File: rtl/dma_copy_mips.sv
// dma_copy_mips: word-copy DMA with memmove semantics on the MIPS data memory port
module dma_copy_mips #(
  parameter int n_bit = 31,
  parameter int memory_size = 2047
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [n_bit:0]   in_src,
  input  logic [n_bit:0]   in_dst,
  input  logic [n_bit:0]   in_len,
  input  logic             in_grant,
  input  logic [n_bit:0]   in_mem_read_data,
  output logic             out_mem_we,
  output logic [n_bit:0]   out_mem_addr,
  output logic [n_bit:0]   out_mem_write_data,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_error
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [n_bit+1:0] one_x = (n_bit+2)'(1);
  localparam logic [n_bit+1:0] lim = (n_bit+2)'(memory_size);
  localparam logic [n_bit:0] one = (n_bit+1)'(1);
  state_t state, next;
  logic [n_bit:0] src_ptr, dst_ptr, cnt, buffer;
  logic err, desc, bad, back;
  logic [n_bit+1:0] src_x, dst_x, src_last, dst_last;
  always_comb begin
    src_x = {1'b0, in_src} + {1'b0, in_len};
    dst_x = {1'b0, in_dst} + {1'b0, in_len};
    src_last = src_x - one_x;
    dst_last = dst_x - one_x;
    bad = (in_len != '0) && (src_last > lim || dst_last > lim);
    back = in_src < in_dst && {1'b0, in_dst} < src_x;
    next = state;
    case (state)
      IDLE:  if (in_start) next = (bad || in_len == '0) ? DONE : READ;
      READ:  if (in_grant) next = WRITE;
      WRITE: if (in_grant) next = cnt == one ? DONE : READ;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
    out_busy = state != IDLE;
    out_done = state == DONE;
    out_error = state == DONE && err;
    // an in-flight write is dropped the moment reset is raised
    out_mem_we = state == WRITE && in_grant && !in_reset;
    out_mem_addr = state == READ ? src_ptr : state == WRITE ? dst_ptr : '0;
    out_mem_write_data = state == WRITE ? buffer : '0;
  end
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt <= '0;
      buffer <= '0;
      err <= 1'b0;
      desc <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (in_start) begin
          err <= bad;
          desc <= back;
          cnt <= in_len;
          src_ptr <= back ? src_last[n_bit:0] : in_src;
          dst_ptr <= back ? dst_last[n_bit:0] : in_dst;
        end
        READ: if (in_grant) buffer <= in_mem_read_data;
        WRITE: if (in_grant) begin
          cnt <= cnt - one;
          src_ptr <= desc ? src_ptr - one : src_ptr + one;
          dst_ptr <= desc ? dst_ptr - one : dst_ptr + one;
        end
        DONE: err <= 1'b0;
        default: err <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_mips.sv
// tb_dma_copy_mips: directed and random copies checked against a memmove model
module tb_dma_copy_mips;
  localparam int MS = 2047;
  logic in_clk = 1'b0;
  logic in_reset, in_start, in_grant, out_mem_we, out_busy, out_done, out_error;
  logic [31:0] in_src, in_dst, in_len, in_mem_read_data, out_mem_addr, out_mem_write_data;
  logic [31:0] mem [0:MS];
  logic [31:0] model [0:MS];
  logic load_en;
  logic [10:0] load_addr;
  logic [31:0] load_data;
  int n_cmp = 0, n_bad = 0;

  dma_copy_mips #(.n_bit(31), .memory_size(MS)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
    .in_src(in_src), .in_dst(in_dst), .in_len(in_len), .in_grant(in_grant),
    .in_mem_read_data(in_mem_read_data), .out_mem_we(out_mem_we),
    .out_mem_addr(out_mem_addr), .out_mem_write_data(out_mem_write_data),
    .out_busy(out_busy), .out_done(out_done), .out_error(out_error)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (out_mem_we && out_mem_addr <= MS) mem[out_mem_addr[10:0]] <= out_mem_write_data;
  end
  assign in_mem_read_data = out_mem_addr <= MS ? mem[out_mem_addr[10:0]] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input logic [31:0] d);
    @(negedge in_clk);
    load_en = 1'b1;
    load_addr = a[10:0];
    load_data = d;
    model[a] = d;
  endtask

  task automatic end_load();
    @(negedge in_clk);
    load_en = 1'b0;
  endtask

  function automatic int region(input int i);
    return i < 256 ? i : i + 1760;
  endfunction

  task automatic preload_random();
    for (int i = 0; i < 288; i++) put(region(i), $urandom);
  endtask

  task automatic compare_mem();
    for (int i = 0; i < 288; i++) chk($sformatf("mem[%0d]", region(i)), mem[region(i)], model[region(i)]);
  endtask

  task automatic model_copy(input int src, input int dst, input int n);
    logic [31:0] tmp [$];
    for (int i = 0; i < n; i++) tmp.push_back(model[src + i]);
    for (int i = 0; i < n; i++) model[dst + i] = tmp[i];
  endtask

  // gmode: 0 grant always, 1 random grant, 2 grant low in cycles slo..shi
  task automatic run_copy(input int src, input int dst, input int len, input int gmode,
                          input int slo, input int shi, input int rst_cyc, input int restart_cyc);
    int grants = 0, nwe = 0, exp_done, got_done = 0, kmax;
    bit exp_err, got_err = 1'b0;
    exp_err = len != 0 && (src + len - 1 > MS || dst + len - 1 > MS);
    exp_done = (len == 0 || exp_err) ? 1 : 0;
    @(negedge in_clk);
    in_src = src; in_dst = dst; in_len = len; in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0; in_src = $urandom; in_dst = $urandom; in_len = $urandom;
    kmax = rst_cyc != 0 ? rst_cyc + 6 : 8 * len + 400;
    for (int k = 1; k <= kmax && got_done == 0; k++) begin
      @(negedge in_clk);
      in_grant = gmode == 0 ? 1'b1 : gmode == 1 ? 1'($urandom_range(0, 1)) : !(k >= slo && k <= shi);
      if (k == restart_cyc) begin in_start = 1'b1; in_src = 5; in_dst = 6; in_len = 1; end
      if (k == restart_cyc + 1) in_start = 1'b0;
      in_reset = rst_cyc != 0 && k == rst_cyc;
      #1;
      if (rst_cyc != 0 && k == rst_cyc + 1) begin
        chk("busy_after_reset", 32'(out_busy), 0);
        chk("we_after_reset", 32'(out_mem_we), 0);
        chk("addr_after_reset", out_mem_addr, 0);
      end
      chk("we_without_grant", 32'(out_mem_we & ~in_grant), 0);
      nwe += int'(out_mem_we);
      if (out_done) begin got_done = k; got_err = out_error; end
      if (exp_done == 0 && in_grant) begin
        grants++;
        if (grants == 2 * len) exp_done = k + 1;
      end
    end
    if (rst_cyc != 0) begin
      chk("no_done_after_reset", got_done, 0);
      chk("writes_before_reset", nwe, (rst_cyc - 1) / 2);
      model_copy(src, dst, (rst_cyc - 1) / 2);
    end else begin
      chk("done_cycle", got_done, exp_done);
      chk("error", 32'(got_err), 32'(exp_err));
      chk("write_count", nwe, exp_err ? 0 : len);
      @(negedge in_clk);
      #1;
      chk("busy_after_done", 32'(out_busy), 0);
      chk("single_done", 32'(out_done), 0);
      if (!exp_err) model_copy(src, dst, len);
    end
    compare_mem();
  endtask

  initial begin
    int s, d, l;
    in_reset = 1'b1; in_start = 1'b0; in_grant = 1'b0;
    in_src = '0; in_dst = '0; in_len = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_we", 32'(out_mem_we), 0);
    chk("rst_addr", out_mem_addr, 0);
    chk("rst_wdata", out_mem_write_data, 0);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_done", 32'(out_done), 0);
    chk("rst_error", 32'(out_error), 0);
    @(negedge in_clk);
    in_reset = 1'b0;
    preload_random(); end_load();
    run_copy(10, 100, 4, 0, 0, 0, 0, 0);
    preload_random();
    for (int i = 0; i < 5; i++) put(i, 32'(i + 1));
    end_load();
    run_copy(0, 2, 5, 0, 0, 0, 0, 0);
    preload_random();
    for (int i = 0; i < 5; i++) put(5 + i, 32'(i + 1));
    end_load();
    run_copy(5, 3, 5, 0, 0, 0, 0, 0);
    run_copy(2040, 0, 16, 0, 0, 0, 0, 0);
    run_copy(20, 30, 0, 0, 0, 0, 0, 0);
    preload_random(); end_load();
    run_copy(40, 60, 2, 2, 2, 4, 0, 0);
    preload_random(); end_load();
    run_copy(70, 120, 8, 0, 0, 0, 6, 0);
    preload_random(); end_load();
    run_copy(30, 50, 6, 0, 0, 0, 0, 3);
    run_copy(44, 44, 4, 1, 0, 0, 0, 0);
    for (int t = 0; t < 25; t++) begin
      preload_random(); end_load();
      l = $urandom_range(0, 24);
      s = $urandom_range(0, 200);
      d = $urandom_range(0, 1) ? $urandom_range(0, 200) : (s >= 10 ? s - 10 + $urandom_range(0, 20) : s + $urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) s = $urandom_range(2016, 2047);
      run_copy(s, d, l, 1, 0, 0, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
